cpu_stall_ctrl: RTL and testbench

// - Parametrised stall/dispatch controller between CPU decode and the pipeline/VPU array.
// - Owns WAIT countdown, multi-channel VPU dispatch (round-robin), sticky HALT, VPU watchdog.
// - Drives the single pipeline stall line; generalises the fixed 11-bit timer / single-VPU scheme.

---
 rtl/cpu_stall_ctrl_pkg.sv | 33 +++
 rtl/cpu_stall_ctrl_vpu_rr_arb.sv | 40 ++++
 rtl/cpu_stall_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_stall_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stall_ctrl_pkg.sv
// Shared definitions for the CPU stall/dispatch controller.
// - Default parameter values used by the controller.
// - FSM state encoding and the qualified-issue struct.
// - idx_w(): index width helper that never returns 0.
package cpu_stall_ctrl_pkg;

  localparam int TIMER_W_DEF = 11;
  localparam int NUM_VPU_DEF = 2;
  localparam int VPU_TO_DEF  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_CNT  = 3'd1,
    ST_VPU_ARB   = 3'd2,
    ST_VPU_START = 3'd3,
    ST_VPU_BUSY  = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  // Decode-stage issue after flush qualification and priority resolution;
  // at most one field is set.
  typedef struct packed {
    logic halt;
    logic vpu;
    logic wt;
  } iss_t;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_stall_ctrl_vpu_rr_arb.sv
// Round-robin arbiter over the VPU channels.
// Ports:
//   req  in  N   request mask (channels available this cycle)
//   ptr  in  IW  first channel to consider
//   gnt  out N   one-hot grant (0 when no request)
//   idx  out IW  index of the granted channel
//   any  out 1   a grant was issued
module cpu_stall_ctrl_vpu_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic          found;
  logic [IW-1:0] pos;

  // Walk channels starting at ptr, wrapping at N; first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/cpu_stall_ctrl.sv
// Stall/dispatch controller between CPU decode and the pipeline/VPU array.
// Owns the WAIT countdown, round-robin VPU dispatch, sticky HALT and a VPU
// watchdog, and drives the single pipeline stall line.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   issue_valid  decoded instruction present
//   is_wait/wait_time, is_vpu, is_halt   decoded instruction class
//   flush        kill of the decode stage
//   vpu_rdy      per-channel ready
//   vpu_start    one-cycle one-hot start pulse
//   vpu_ch       channel of current/last grant
//   stall        freeze fetch/decode (combinational)
//   halted       sticky halt indicator
//   timeout_err  sticky watchdog flag
module cpu_stall_ctrl
  import cpu_stall_ctrl_pkg::*;
#(
  parameter  int TIMER_W  = TIMER_W_DEF,
  parameter  int NUM_VPU  = NUM_VPU_DEF,
  parameter  int BLOCKING = 1,
  parameter  int VPU_TO   = VPU_TO_DEF,
  localparam int CH_W     = idx_w(NUM_VPU)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic               is_wait,
  input  logic [TIMER_W-1:0] wait_time,
  input  logic               is_vpu,
  input  logic               is_halt,
  input  logic               flush,
  input  logic [NUM_VPU-1:0] vpu_rdy,
  output logic [NUM_VPU-1:0] vpu_start,
  output logic [CH_W-1:0]    vpu_ch,
  output logic               stall,
  output logic               halted,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(VPU_TO + 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_VPU-1:0] pend_a_q, pend_a_d;  // set during the start cycle
  logic [NUM_VPU-1:0] pend_b_q, pend_b_d;  // set the cycle after
  logic               abort_q, abort_d;
  logic               terr_q, terr_d;

  logic               go;
  iss_t               iss;
  logic [NUM_VPU-1:0] avail;
  logic [NUM_VPU-1:0] arb_gnt;
  logic [CH_W-1:0]    arb_idx;
  logic               arb_any;
  logic               wd_hit;

  assign go = issue_valid & ~flush;

  always_comb begin
    iss.halt = go & is_halt;
    iss.vpu  = go & is_vpu & ~is_halt;
    iss.wt   = go & is_wait & ~is_halt & ~is_vpu & (wait_time != '0);
  end

  // A channel just started may still show the ready level from before it
  // saw the start pulse; keep it masked for two cycles.
  assign avail  = vpu_rdy & ~(pend_a_q | pend_b_q);
  assign wd_hit = (wdog_q == WD_W'(VPU_TO - 1));

  cpu_stall_ctrl_vpu_rr_arb #(
    .N  (NUM_VPU),
    .IW (CH_W)
  ) u_vpu_rr_arb (
    .req (avail),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      wdog_q   <= '0;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      pend_a_q <= '0;
      pend_b_q <= '0;
      abort_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wdog_q   <= wdog_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      abort_q  <= abort_d;
      terr_q   <= terr_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wdog_d   = wdog_q;
    rr_ptr_d = rr_ptr_q;
    ch_d     = ch_q;
    pend_a_d = '0;
    pend_b_d = pend_a_q;
    abort_d  = 1'b0;
    terr_d   = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (iss.halt) begin
          state_d = ST_HALTED;
        end else if (iss.vpu) begin
          state_d = ST_VPU_ARB;
          wdog_d  = '0;
        end else if (iss.wt) begin
          // The decode cycle is the first stall cycle, so WAIT 1 never
          // leaves IDLE.
          timer_d = wait_time - TIMER_W'(1);
          if (wait_time != TIMER_W'(1)) state_d = ST_WAIT_CNT;
        end
      end
      ST_WAIT_CNT: begin
        if (abort_q) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
          if (timer_q <= TIMER_W'(1)) state_d = ST_IDLE;
          else if (flush)             abort_d = 1'b1;
        end
      end
      ST_VPU_ARB: begin
        if (abort_q) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else if (flush) begin
          // Hold stall one more cycle, then drop back without granting.
          abort_d = 1'b1;
          wdog_d  = wdog_q + WD_W'(1);
        end else if (arb_any) begin
          state_d  = ST_VPU_START;
          ch_d     = arb_idx;
          rr_ptr_d = (arb_idx == CH_W'(NUM_VPU - 1)) ? '0 : arb_idx + CH_W'(1);
          pend_a_d = arb_gnt;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_VPU_START: begin
        if (BLOCKING != 0) begin
          state_d = ST_VPU_BUSY;
          wdog_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VPU_BUSY: begin
        if (avail[ch_q]) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs. stall and vpu_start are forced low while reset is asserted so
  // no start pulse escapes during a mid-operation reset.
  always_comb begin
    stall     = 1'b0;
    vpu_start = '0;
    case (state_q)
      ST_IDLE: stall = |iss;
      ST_VPU_START: begin
        stall           = 1'b1;
        vpu_start[ch_q] = 1'b1;
      end
      default: stall = 1'b1;
    endcase
    if (!rst_n) begin
      stall     = 1'b0;
      vpu_start = '0;
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign timeout_err = terr_q;
  assign vpu_ch      = ch_q;

endmodule

// File: tb/tb_cpu_stall_ctrl.sv
module tb_cpu_stall_ctrl;

  localparam int TW = 11;
  localparam int NV = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          is_wait = 1'b0;
  logic [TW-1:0] wait_time = '0;
  logic          is_vpu = 1'b0;
  logic          is_halt = 1'b0;
  logic          flush = 1'b0;
  logic [NV-1:0] vpu_rdy = 2'b11;

  logic [NV-1:0] start_b, start_n;
  logic          ch_b, ch_n;
  logic          stall_b, stall_n;
  logic          halted_b, halted_n;
  logic          terr_b, terr_n;

  always #5 clk = ~clk;

  cpu_stall_ctrl #(.TIMER_W(TW), .NUM_VPU(NV), .BLOCKING(1), .VPU_TO(TO)) u_blk (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .is_wait(is_wait),
    .wait_time(wait_time), .is_vpu(is_vpu), .is_halt(is_halt), .flush(flush),
    .vpu_rdy(vpu_rdy), .vpu_start(start_b), .vpu_ch(ch_b), .stall(stall_b),
    .halted(halted_b), .timeout_err(terr_b)
  );

  cpu_stall_ctrl #(.TIMER_W(TW), .NUM_VPU(NV), .BLOCKING(0), .VPU_TO(TO)) u_nb (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .is_wait(is_wait),
    .wait_time(wait_time), .is_vpu(is_vpu), .is_halt(is_halt), .flush(flush),
    .vpu_rdy(vpu_rdy), .vpu_start(start_n), .vpu_ch(ch_n), .stall(stall_n),
    .halted(halted_n), .timeout_err(terr_n)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // sel=1 checks the blocking instance, sel=0 the non-blocking one.
  typedef struct {
    string         tag;
    bit            sel;
    bit            stall;
    bit [NV-1:0]   start;
    bit            halted;
    bit            terr;
    bit            chk_ch;
    bit            ch;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m = sb.pop_front();
      chk({m.tag, "/stall"},  m.sel ? 32'(stall_b)  : 32'(stall_n),  32'(m.stall));
      chk({m.tag, "/start"},  m.sel ? 32'(start_b)  : 32'(start_n),  32'(m.start));
      chk({m.tag, "/halted"}, m.sel ? 32'(halted_b) : 32'(halted_n), 32'(m.halted));
      chk({m.tag, "/terr"},   m.sel ? 32'(terr_b)   : 32'(terr_n),   32'(m.terr));
      if (m.chk_ch)
        chk({m.tag, "/ch"},   m.sel ? 32'(ch_b)     : 32'(ch_n),     32'(m.ch));
    end
  end

  task automatic drv(input bit iv, input bit w, input int wt, input bit v, input bit h, input bit f);
    issue_valid = iv; is_wait = w; wait_time = TW'(wt); is_vpu = v; is_halt = h; flush = f;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input string tag, input bit sel, input bit s, input bit [NV-1:0] vs,
                      input bit hl, input bit te, input bit cc, input bit ch);
    exp_t e;
    e.tag = tag; e.sel = sel; e.stall = s; e.start = vs;
    e.halted = hl; e.terr = te; e.chk_ch = cc; e.ch = ch;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic st(input string tag, input bit sel, input bit s, input bit [NV-1:0] vs,
                    input bit hl, input bit te);
    push(tag, sel, s, vs, hl, te, 1'b0, 1'b0);
  endtask

  task automatic stc(input string tag, input bit sel, input bit s, input bit [NV-1:0] vs,
                     input bit hl, input bit te, input bit ch);
    push(tag, sel, s, vs, hl, te, 1'b1, ch);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    vpu_rdy = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    rst_n = 1'b1;
    stc("reset_b", 1, 0, 2'b00, 0, 0, 0);
    stc("reset_n", 0, 0, 2'b00, 0, 0, 0);

    // WAIT 3 / 0 / 1
    drv(1, 1, 3, 0, 0, 0); st("w3_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("w3_c1", 1, 1, 2'b00, 0, 0);
                           st("w3_c2", 1, 1, 2'b00, 0, 0);
                           st("w3_c3", 1, 0, 2'b00, 0, 0);
    drv(1, 1, 0, 0, 0, 0); st("w0_c0", 1, 0, 2'b00, 0, 0);
    idle();                st("w0_c1", 1, 0, 2'b00, 0, 0);
    drv(1, 1, 1, 0, 0, 0); st("w1_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("w1_c1", 1, 0, 2'b00, 0, 0);

    // WAIT 10 with flush at cycle 2
    drv(1, 1, 10, 0, 0, 0); st("wf_c0", 1, 1, 2'b00, 0, 0);
    idle();                 st("wf_c1", 1, 1, 2'b00, 0, 0);
    drv(0, 0, 0, 0, 0, 1);  st("wf_c2", 1, 1, 2'b00, 0, 0);
    idle();                 st("wf_c3", 1, 1, 2'b00, 0, 0);
                            st("wf_c4", 1, 0, 2'b00, 0, 0);
                            st("wf_c5", 1, 0, 2'b00, 0, 0);

    // issue + flush in the same cycle is ignored
    drv(1, 1, 5, 0, 0, 1); st("if_wait", 1, 0, 2'b00, 0, 0);
    drv(1, 0, 0, 1, 0, 1); st("if_vpu",  1, 0, 2'b00, 0, 0);
    idle();                st("if_c2",   1, 0, 2'b00, 0, 0);
                           st("if_c3",   1, 0, 2'b00, 0, 0);

    // Non-blocking: two VPU issues, round-robin 0 then 1 (vpu beats wait)
    do_reset();
    drv(1, 0, 0, 1, 0, 0); st("nb1_c0", 0, 1, 2'b00, 0, 0);
    idle();                st("nb1_arb", 0, 1, 2'b00, 0, 0);
                           stc("nb1_start", 0, 1, 2'b01, 0, 0, 0);
    drv(1, 1, 1, 1, 0, 0); st("nb2_c0", 0, 1, 2'b00, 0, 0);
    idle();                st("nb2_arb", 0, 1, 2'b00, 0, 0);
                           stc("nb2_start", 0, 1, 2'b10, 0, 0, 1);
                           stc("nb2_done", 0, 0, 2'b00, 0, 0, 1);

    // Pointer at 0 but only channel 1 ready
    do_reset();
    vpu_rdy = 2'b10;
    drv(1, 0, 0, 1, 0, 0); st("sk_c0", 0, 1, 2'b00, 0, 0);
    idle();                st("sk_arb", 0, 1, 2'b00, 0, 0);
                           stc("sk_start", 0, 1, 2'b10, 0, 0, 1);
                           st("sk_done", 0, 0, 2'b00, 0, 0);

    // Blocking: rdy[0] drops after start, returns 5 cycles later
    do_reset();
    drv(1, 0, 0, 1, 0, 0); st("b1_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("b1_arb", 1, 1, 2'b00, 0, 0);
                           stc("b1_start", 1, 1, 2'b01, 0, 0, 0);
    vpu_rdy = 2'b10;
    for (int i = 0; i < 5; i++) st("b1_busy", 1, 1, 2'b00, 0, 0);
    vpu_rdy = 2'b11;       st("b1_ret", 1, 1, 2'b00, 0, 0);
                           st("b1_rel", 1, 0, 2'b00, 0, 0);
    // Blocking with rdy held high: first busy cycle ignores stale ready
    drv(1, 0, 0, 1, 0, 0); st("b2_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("b2_arb", 1, 1, 2'b00, 0, 0);
                           stc("b2_start", 1, 1, 2'b10, 0, 0, 1);
                           st("b2_busy0", 1, 1, 2'b00, 0, 0);
                           st("b2_busy1", 1, 1, 2'b00, 0, 0);
                           st("b2_rel", 1, 0, 2'b00, 0, 0);

    // flush during START/BUSY has no effect
    drv(1, 0, 0, 1, 0, 0); st("fs_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("fs_arb", 1, 1, 2'b00, 0, 0);
    drv(0, 0, 0, 0, 0, 1); stc("fs_start", 1, 1, 2'b01, 0, 0, 0);
                           st("fs_busy0", 1, 1, 2'b00, 0, 0);
    idle();                st("fs_busy1", 1, 1, 2'b00, 0, 0);
                           st("fs_rel", 1, 0, 2'b00, 0, 0);

    // flush during VPU_ARB aborts, no grant even if ready appears
    do_reset();
    vpu_rdy = 2'b00;
    drv(1, 0, 0, 1, 0, 0); st("fa_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("fa_arb", 1, 1, 2'b00, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    vpu_rdy = 2'b11;       st("fa_flush", 1, 1, 2'b00, 0, 0);
    idle();                st("fa_abort", 1, 1, 2'b00, 0, 0);
                           st("fa_rel", 1, 0, 2'b00, 0, 0);
                           st("fa_rel2", 1, 0, 2'b00, 0, 0);

    // Watchdog: nothing ready, 17 stall cycles then sticky timeout
    do_reset();
    vpu_rdy = 2'b00;
    drv(1, 0, 0, 1, 0, 0); st("to_c0", 1, 1, 2'b00, 0, 0);
    idle();
    for (int i = 0; i < TO; i++) st("to_arb", 1, 1, 2'b00, 0, 0);
                           st("to_rel", 1, 0, 2'b00, 0, 1);
                           st("to_rel_nb", 0, 0, 2'b00, 0, 1);
    drv(1, 1, 2, 0, 0, 0); st("to_w0", 1, 1, 2'b00, 0, 1);
    idle();                st("to_w1", 1, 1, 2'b00, 0, 1);
                           st("to_w2", 1, 0, 2'b00, 0, 1);

    // Reset asserted in the start cycle suppresses the pulse
    do_reset();
    drv(1, 0, 0, 1, 0, 0); st("rs_c0", 0, 1, 2'b00, 0, 0);
    idle();                st("rs_arb", 0, 1, 2'b00, 0, 0);
    rst_n = 1'b0;          st("rs_start", 0, 0, 2'b00, 0, 0);
    rst_n = 1'b1;          stc("rs_after", 0, 0, 2'b00, 0, 0, 0);

    // HALT has priority and holds through later issues until reset
    drv(1, 1, 3, 1, 1, 0); st("h_c0", 1, 1, 2'b00, 0, 0);
    idle();                st("h_c1", 1, 1, 2'b00, 1, 0);
    drv(1, 0, 0, 1, 0, 0); st("h_vpu", 1, 1, 2'b00, 1, 0);
    drv(1, 1, 2, 0, 0, 0); st("h_wait", 1, 1, 2'b00, 1, 0);
    idle();                st("h_c4", 1, 1, 2'b00, 1, 0);
                           st("h_c5_nb", 0, 1, 2'b00, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stc("h_rst_b", 1, 0, 2'b00, 0, 0, 0);
    stc("h_rst_n", 0, 0, 2'b00, 0, 0, 0);

    @(posedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
